regfile_sb: RTL and testbench

Parametrised integer register file for the RISC-V core: configurable data width, register count and read-port count, two write ports for dual writeback, optional same-cycle write-to-read bypass, and a per-register busy scoreboard that issue logic uses to detect RAW hazards. It replaces the single-write, two-read register file between decode and writeback. Register 0 is hardwired to zero.

---
 rtl/regfile_sb_if.sv | 31 +++
 rtl/regfile_sb.sv | 92 +++++++++
 tb/tb_regfile_sb.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Register-file bus: write ports, read ports, busy scoreboard set/query.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AWID = $clog2(NREG);

  logic                 WE0;
  logic [AWID-1:0]      AW0;
  logic [XLEN-1:0]      D0;
  logic                 WE1;
  logic [AWID-1:0]      AW1;
  logic [XLEN-1:0]      D1;
  logic [NRD*AWID-1:0]  AR;
  logic [NRD*XLEN-1:0]  Q;
  logic [NRD-1:0]       BUSY;
  logic                 SET;
  logic [AWID-1:0]      SA;
  logic [AWID:0]        BUSY_CNT;

  modport master (
    output WE0, AW0, D0, WE1, AW1, D1, AR, SET, SA,
    input  Q, BUSY, BUSY_CNT
  );

  modport slave (
    input  WE0, AW0, D0, WE1, AW1, D1, AR, SET, SA,
    output Q, BUSY, BUSY_CNT
  );
endinterface

// File: rtl/regfile_sb.sv
// Dual-write, NRD-read integer register file with optional write bypass
// and a per-register busy scoreboard for RAW hazard detection.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic        CLK,
  input  logic        RST,
  regfile_sb_if.slave bus
);
  localparam int AWID = $clog2(NREG);

  logic [NREG-1:0][XLEN-1:0] regs_q;
  logic [NREG-1:0]           busy_q, busy_d;
  logic [AWID:0]             cnt_q, cnt_d;

  logic wr0, wr1, set_v;
  logic inc, dec0, dec1;

  assign wr0   = bus.WE0 && (bus.AW0 != '0);
  assign wr1   = bus.WE1 && (bus.AW1 != '0);
  assign set_v = bus.SET && (bus.SA != '0);

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge CLK) begin
    if (RST) begin
      regs_q <= '0;
    end else begin
      if (wr0) regs_q[bus.AW0] <= bus.D0;
      if (wr1) regs_q[bus.AW1] <= bus.D1;
    end
  end

  // Set is applied after clears: a new producer supersedes the old one.
  always_comb begin
    busy_d = busy_q;
    if (wr0)   busy_d[bus.AW0] = 1'b0;
    if (wr1)   busy_d[bus.AW1] = 1'b0;
    if (set_v) busy_d[bus.SA]  = 1'b1;
  end

  // Incremental popcount; a dual write to one register decrements once.
  always_comb begin
    inc   = set_v && !busy_q[bus.SA];
    dec0  = wr0 && busy_q[bus.AW0] && !(set_v && bus.SA == bus.AW0);
    dec1  = wr1 && busy_q[bus.AW1] && !(set_v && bus.SA == bus.AW1)
            && !(wr0 && bus.AW0 == bus.AW1);
    cnt_d = cnt_q + {{AWID{1'b0}}, inc} - {{AWID{1'b0}}, dec0}
                  - {{AWID{1'b0}}, dec1};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  logic [NRD-1:0][XLEN-1:0] q_rd;
  logic [NRD-1:0]           b_rd;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AWID-1:0] ar;
    logic            hit0, hit1;
    assign ar   = bus.AR[k*AWID +: AWID];
    assign hit0 = wr0 && (bus.AW0 == ar);
    assign hit1 = wr1 && (bus.AW1 == ar);

    always_comb begin
      q_rd[k] = regs_q[ar];
      b_rd[k] = busy_q[ar];
      if (BYPASS != 0) begin
        if (hit1)      q_rd[k] = bus.D1;
        else if (hit0) q_rd[k] = bus.D0;
        if ((hit0 || hit1) && !(set_v && bus.SA == ar)) b_rd[k] = 1'b0;
      end
      if (ar == '0) begin
        q_rd[k] = '0;
        b_rd[k] = 1'b0;
      end
    end
  end

  assign bus.Q        = q_rd;
  assign bus.BUSY     = b_rd;
  assign bus.BUSY_CNT = cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: bypass and non-bypass instances share stimulus;
// table vectors go through a scoreboard queue, corner sequences are inline.
module tb_regfile_sb;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  regfile_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) bus ();
  regfile_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) nbus ();

  regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );
  regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0)) dut_nb (
    .CLK(CLK), .RST(RST), .bus(nbus)
  );

  assign nbus.WE0 = bus.WE0;
  assign nbus.AW0 = bus.AW0;
  assign nbus.D0  = bus.D0;
  assign nbus.WE1 = bus.WE1;
  assign nbus.AW1 = bus.AW1;
  assign nbus.D1  = bus.D1;
  assign nbus.AR  = bus.AR;
  assign nbus.SET = bus.SET;
  assign nbus.SA  = bus.SA;

  typedef struct {
    logic [31:0] we0, aw0, d0, we1, aw1, d1, set, sa, ar0, ar1;
    logic [31:0] q0, q1, b0, b1, cnt, nq1, nb1;
  } vec_t;

  vec_t vecs[15];
  vec_t sb[$];
  vec_t e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.WE0 = 1'b0; bus.AW0 = '0; bus.D0 = '0;
    bus.WE1 = 1'b0; bus.AW1 = '0; bus.D1 = '0;
    bus.SET = 1'b0; bus.SA  = '0;
  endtask

  task automatic set_ar(input logic [4:0] a0, input logic [4:0] a1);
    bus.AR = {a1, a0};
  endtask

  initial begin
    // we0 aw0 d0 we1 aw1 d1 set sa ar0 ar1 | q0 q1 b0 b1 cnt nq1 nb1
    vecs[0]  = '{1,5,32'hDEADBEEF,0,0,0,0,0,5,5, 32'hDEADBEEF,32'hDEADBEEF,0,0,0,0,0};
    vecs[1]  = '{1,0,32'h1234,0,0,0,0,0,5,0, 32'hDEADBEEF,0,0,0,0,0,0};
    vecs[2]  = '{0,0,0,0,0,0,0,0,0,5, 0,32'hDEADBEEF,0,0,0,32'hDEADBEEF,0};
    vecs[3]  = '{1,7,32'h11,1,7,32'h22,0,0,7,7, 32'h22,32'h22,0,0,0,0,0};
    vecs[4]  = '{0,0,0,0,0,0,0,0,7,7, 32'h22,32'h22,0,0,0,32'h22,0};
    vecs[5]  = '{0,0,0,0,0,0,1,3,3,3, 0,0,0,0,0,0,0};
    vecs[6]  = '{0,0,0,1,3,32'h55,0,0,3,3, 32'h55,32'h55,0,0,1,0,1};
    vecs[7]  = '{0,0,0,0,0,0,0,0,3,3, 32'h55,32'h55,0,0,0,32'h55,0};
    vecs[8]  = '{0,0,0,0,0,0,1,9,9,9, 0,0,0,0,0,0,0};
    vecs[9]  = '{1,9,32'h99,0,0,0,1,9,9,9, 32'h99,32'h99,1,1,1,0,1};
    vecs[10] = '{0,0,0,0,0,0,0,0,9,9, 32'h99,32'h99,1,1,1,32'h99,1};
    vecs[11] = '{1,9,32'hA,1,9,32'hB,0,0,9,9, 32'hB,32'hB,0,0,1,32'h99,1};
    vecs[12] = '{0,0,0,0,0,0,0,0,9,9, 32'hB,32'hB,0,0,0,32'hB,0};
    vecs[13] = '{1,4,32'h1,0,0,0,0,0,4,4, 32'h1,32'h1,0,0,0,0,0};
    vecs[14] = '{0,0,0,0,0,0,0,0,4,4, 32'h1,32'h1,0,0,0,32'h1,0};

    RST = 1'b1;
    idle();
    set_ar(5'd0, 5'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    for (int a = 0; a < 32; a++) begin
      @(negedge CLK);
      set_ar(a[4:0], 5'(31 - a));
      #1;
      chk("rst_q0",   bus.Q[31:0], 32'h0);
      chk("rst_q1",   bus.Q[63:32], 32'h0);
      chk("rst_busy", {30'b0, bus.BUSY}, 32'h0);
      chk("rst_cnt",  {26'b0, bus.BUSY_CNT}, 32'h0);
    end

    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      bus.WE0 = vecs[i].we0[0]; bus.AW0 = vecs[i].aw0[4:0]; bus.D0 = vecs[i].d0;
      bus.WE1 = vecs[i].we1[0]; bus.AW1 = vecs[i].aw1[4:0]; bus.D1 = vecs[i].d1;
      bus.SET = vecs[i].set[0]; bus.SA  = vecs[i].sa[4:0];
      set_ar(vecs[i].ar0[4:0], vecs[i].ar1[4:0]);
      sb.push_back(vecs[i]);
      #2;
      e = sb.pop_front();
      chk($sformatf("v%0d_q0", i),  bus.Q[31:0], e.q0);
      chk($sformatf("v%0d_q1", i),  bus.Q[63:32], e.q1);
      chk($sformatf("v%0d_b0", i),  {31'b0, bus.BUSY[0]}, e.b0);
      chk($sformatf("v%0d_b1", i),  {31'b0, bus.BUSY[1]}, e.b1);
      chk($sformatf("v%0d_cnt", i), {26'b0, bus.BUSY_CNT}, e.cnt);
      chk($sformatf("v%0d_nq1", i), nbus.Q[63:32], e.nq1);
      chk($sformatf("v%0d_nb1", i), {31'b0, nbus.BUSY[1]}, e.nb1);
    end

    // Saturate the scoreboard, then reset with a write and a set in flight.
    for (int a = 1; a < 32; a++) begin
      @(negedge CLK);
      idle();
      bus.SET = 1'b1;
      bus.SA  = a[4:0];
    end
    @(negedge CLK);
    idle();
    set_ar(5'd31, 5'd1);
    #2;
    chk("full_cnt", {26'b0, bus.BUSY_CNT}, 32'd31);
    chk("full_b31", {31'b0, bus.BUSY[0]}, 32'd1);
    chk("full_b1",  {31'b0, bus.BUSY[1]}, 32'd1);

    @(negedge CLK);
    RST = 1'b1;
    bus.WE0 = 1'b1; bus.AW0 = 5'd12; bus.D0 = 32'hFF;
    bus.SET = 1'b1; bus.SA  = 5'd12;
    @(negedge CLK);
    RST = 1'b0;
    idle();
    #2;
    chk("mid_rst_cnt", {26'b0, bus.BUSY_CNT}, 32'h0);
    for (int a = 0; a < 32; a++) begin
      @(negedge CLK);
      set_ar(a[4:0], 5'(31 - a));
      #1;
      chk($sformatf("mid_rst_q0_r%0d", a), bus.Q[31:0], 32'h0);
      chk($sformatf("mid_rst_q1_r%0d", a), bus.Q[63:32], 32'h0);
      chk($sformatf("mid_rst_busy_r%0d", a), {30'b0, bus.BUSY}, 32'h0);
    end
    chk("mid_rst_cnt_end", {26'b0, bus.BUSY_CNT}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
